// File: rtl/axi_rr_master_arbiter.sv
// N-master AXI arbiter: round-robin AW/AR grants that stay locked until their handshake,
// a write-order queue that steers W in AW order, and ID-decoded B/R demux selects.

// One address channel: round-robin pick, grant lock until handshake, pointer rotation.
module axi_rr_master_arbiter_chan #(
    parameter int N_MASTER = 4,
    parameter int SEL_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_MASTER-1:0] i_valid,
    input  logic                i_ready,
    input  logic                i_block,
    output logic [SEL_W-1:0]    o_sel,
    output logic                o_grant_valid,
    output logic                o_hs
);

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // First requester after ptr, wrapping modulo N_MASTER (need not be a power of two).
    function automatic pick_t rr_pick(input logic [N_MASTER-1:0] valid,
                                      input logic [SEL_W-1:0]    ptr);
        pick_t res;
        int    j;
        res = '0;
        for (int k = 1; k <= N_MASTER; k++) begin
            j = int'(ptr) + k;
            if (j >= N_MASTER) begin
                j = j - N_MASTER;
            end
            if (!res.found && valid[SEL_W'(j)]) begin
                res.found = 1'b1;
                res.idx   = SEL_W'(j);
            end
        end
        return res;
    endfunction

    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_sel;
    logic             r_lock;
    pick_t            w_pick;
    logic [SEL_W-1:0] w_sel;
    logic             w_grant_valid;
    logic             w_hs;

    assign w_pick = rr_pick(i_valid, r_ptr);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
        w_sel         = r_sel;
        w_grant_valid = 1'b0;
        if (r_lock) begin
            w_grant_valid = i_valid[r_sel];
        end else if (w_pick.found) begin
            w_sel         = w_pick.idx;
            w_grant_valid = ~i_block;
        end
    end

    assign w_hs = w_grant_valid & i_ready;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= SEL_W'(N_MASTER - 1);
            r_sel  <= '0;
            r_lock <= 1'b0;
        end else begin
            r_sel <= w_sel;
            if (w_hs) begin
                r_ptr  <= w_sel;
                r_lock <= 1'b0;
            end else if (w_grant_valid) begin
                r_lock <= 1'b1;
            end
        end
    end

    assign o_sel         = w_sel;
    assign o_grant_valid = w_grant_valid;
    assign o_hs          = w_hs;

    // A locked grant never moves to another master.
    a_lock_holds_sel: assert property (@(posedge clk) disable iff (rst)
        r_lock |-> (w_sel == r_sel));

endmodule

module axi_rr_master_arbiter #(
    parameter  int N_MASTER = 4,
    parameter  int M_ID     = 2,
    parameter  int ID_W     = 8,
    parameter  int WQ_DEPTH = 4,
    localparam int SEL_W    = (N_MASTER > 1) ? $clog2(N_MASTER) : 1,
    localparam int CNT_W    = $clog2(WQ_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_MASTER-1:0] m_wr_addr_valid,
    input  logic [N_MASTER-1:0] m_rd_addr_valid,
    input  logic                bus_wr_addr_ready,
    input  logic                bus_wr_data_valid,
    input  logic                bus_wr_data_ready,
    input  logic                bus_wr_data_last,
    input  logic                bus_rd_addr_ready,
    input  logic [ID_W-1:0]     bus_wr_back_id,
    input  logic [ID_W-1:0]     bus_rd_back_id,
    output logic [SEL_W-1:0]    wr_addr_master_sel,
    output logic                wr_addr_grant_valid,
    output logic [SEL_W-1:0]    wr_data_master_sel,
    output logic                wr_data_sel_valid,
    output logic [SEL_W-1:0]    wr_resp_master_sel,
    output logic                wr_resp_id_err,
    output logic [SEL_W-1:0]    rd_addr_master_sel,
    output logic                rd_addr_grant_valid,
    output logic [SEL_W-1:0]    rd_data_master_sel,
    output logic                rd_data_id_err,
    output logic [CNT_W-1:0]    wq_count
);

    localparam int QP_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;

    function automatic logic [QP_W-1:0] wq_next(input logic [QP_W-1:0] p);
        return (int'(p) == WQ_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    logic [SEL_W-1:0] w_aw_sel;
    logic             w_aw_grant_valid;
    logic             w_aw_hs;
    logic [SEL_W-1:0] w_ar_sel;
    logic             w_ar_grant_valid;
    logic             w_unused_ar_hs;
    logic             w_wq_full;
    logic             w_wq_nonempty;
    logic             w_push;
    logic             w_pop;

    logic [SEL_W-1:0] r_wq_mem [WQ_DEPTH];
    logic [QP_W-1:0]  r_wq_rd_ptr;
    logic [QP_W-1:0]  r_wq_wr_ptr;
    logic [CNT_W-1:0] r_wq_count;

    // A full write-order queue holds off new AW grants; AR has no such limit.
    axi_rr_master_arbiter_chan #(
        .N_MASTER (N_MASTER),
        .SEL_W    (SEL_W)
    ) u_aw_chan (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (m_wr_addr_valid),
        .i_ready       (bus_wr_addr_ready),
        .i_block       (w_wq_full),
        .o_sel         (w_aw_sel),
        .o_grant_valid (w_aw_grant_valid),
        .o_hs          (w_aw_hs)
    );

    axi_rr_master_arbiter_chan #(
        .N_MASTER (N_MASTER),
        .SEL_W    (SEL_W)
    ) u_ar_chan (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (m_rd_addr_valid),
        .i_ready       (bus_rd_addr_ready),
        .i_block       (1'b0),
        .o_sel         (w_ar_sel),
        .o_grant_valid (w_ar_grant_valid),
        .o_hs          (w_unused_ar_hs)
    );

    assign w_wq_full     = (r_wq_count == CNT_W'(WQ_DEPTH));
    assign w_wq_nonempty = (r_wq_count != '0);
    assign w_push        = w_aw_hs;
    assign w_pop         = bus_wr_data_valid & bus_wr_data_ready & bus_wr_data_last & w_wq_nonempty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wq_rd_ptr <= '0;
            r_wq_wr_ptr <= '0;
            r_wq_count  <= '0;
            // NOTE: queue entries are cleared as well so no stale index survives a reset.
            for (int i = 0; i < WQ_DEPTH; i++) begin
                r_wq_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_wq_mem[r_wq_wr_ptr] <= w_aw_sel;
                r_wq_wr_ptr           <= wq_next(r_wq_wr_ptr);
            end
            if (w_pop) begin
                r_wq_rd_ptr <= wq_next(r_wq_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_wq_count <= r_wq_count + 1'b1;
                2'b01:   r_wq_count <= r_wq_count - 1'b1;
                default: r_wq_count <= r_wq_count;
            endcase
        end
    end

    // Response routing comes straight from the master-index field of the returned ID.
    logic [SEL_W-1:0] w_wr_resp_idx;
    logic [SEL_W-1:0] w_rd_data_idx;
    logic             w_unused_id;

    assign w_wr_resp_idx  = bus_wr_back_id[M_ID +: SEL_W];
    assign w_rd_data_idx  = bus_rd_back_id[M_ID +: SEL_W];
    assign w_unused_id    = ^{bus_wr_back_id, bus_rd_back_id};

    assign wr_resp_id_err = (int'(w_wr_resp_idx) >= N_MASTER);
    assign rd_data_id_err = (int'(w_rd_data_idx) >= N_MASTER);

    assign wr_addr_master_sel  = rst ? '0 : w_aw_sel;
    assign wr_addr_grant_valid = ~rst & w_aw_grant_valid;
    assign rd_addr_master_sel  = rst ? '0 : w_ar_sel;
    assign rd_addr_grant_valid = ~rst & w_ar_grant_valid;
    assign wr_data_master_sel  = (rst || !w_wq_nonempty) ? '0 : r_wq_mem[r_wq_rd_ptr];
    assign wr_data_sel_valid   = w_wq_nonempty;
    assign wr_resp_master_sel  = (rst || wr_resp_id_err) ? '0 : w_wr_resp_idx;
    assign rd_data_master_sel  = (rst || rd_data_id_err) ? '0 : w_rd_data_idx;
    assign wq_count            = r_wq_count;

    a_count_in_range: assert property (@(posedge clk) disable iff (rst)
        r_wq_count <= CNT_W'(WQ_DEPTH));
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        w_push |-> !w_wq_full);

endmodule

// File: tb/tb_axi_rr_master_arbiter.sv
// Directed bench for axi_rr_master_arbiter: stimulus pushes hand-computed expectations
// into a scoreboard queue; a negedge monitor pops and compares them against the DUT.
module tb_axi_rr_master_arbiter;

    localparam int N  = 4;
    localparam int N3 = 3;

    typedef enum int {
        S_AW_SEL, S_AW_GV, S_AR_SEL, S_AR_GV, S_WD_SEL, S_WD_VALID, S_COUNT,
        S_WR_SEL, S_WR_ERR, S_RD_SEL, S_RD_ERR,
        S3_WR_SEL, S3_WR_ERR, S3_RD_SEL, S3_RD_ERR
    } sig_e;

    typedef struct {
        int   cyc;
        sig_e sig;
        int   val;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] m_wr_addr_valid = '0;
    logic [N-1:0] m_rd_addr_valid = '0;
    logic         bus_wr_addr_ready = 1'b0;
    logic         bus_wr_data_valid = 1'b0;
    logic         bus_wr_data_ready = 1'b0;
    logic         bus_wr_data_last  = 1'b0;
    logic         bus_rd_addr_ready = 1'b0;
    logic [7:0]   bus_wr_back_id = '0;
    logic [7:0]   bus_rd_back_id = '0;

    logic [1:0] wr_addr_master_sel, wr_data_master_sel, wr_resp_master_sel;
    logic [1:0] rd_addr_master_sel, rd_data_master_sel;
    logic       wr_addr_grant_valid, wr_data_sel_valid, wr_resp_id_err;
    logic       rd_addr_grant_valid, rd_data_id_err;
    logic [2:0] wq_count;

    logic [1:0] d3_wr_addr_master_sel, d3_wr_data_master_sel, d3_wr_resp_master_sel;
    logic [1:0] d3_rd_addr_master_sel, d3_rd_data_master_sel;
    logic       d3_wr_addr_grant_valid, d3_wr_data_sel_valid, d3_wr_resp_id_err;
    logic       d3_rd_addr_grant_valid, d3_rd_data_id_err;
    logic [2:0] d3_wq_count;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_rr_master_arbiter #(.N_MASTER(N), .M_ID(2), .ID_W(8), .WQ_DEPTH(4)) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .m_wr_addr_valid     (m_wr_addr_valid),
        .m_rd_addr_valid     (m_rd_addr_valid),
        .bus_wr_addr_ready   (bus_wr_addr_ready),
        .bus_wr_data_valid   (bus_wr_data_valid),
        .bus_wr_data_ready   (bus_wr_data_ready),
        .bus_wr_data_last    (bus_wr_data_last),
        .bus_rd_addr_ready   (bus_rd_addr_ready),
        .bus_wr_back_id      (bus_wr_back_id),
        .bus_rd_back_id      (bus_rd_back_id),
        .wr_addr_master_sel  (wr_addr_master_sel),
        .wr_addr_grant_valid (wr_addr_grant_valid),
        .wr_data_master_sel  (wr_data_master_sel),
        .wr_data_sel_valid   (wr_data_sel_valid),
        .wr_resp_master_sel  (wr_resp_master_sel),
        .wr_resp_id_err      (wr_resp_id_err),
        .rd_addr_master_sel  (rd_addr_master_sel),
        .rd_addr_grant_valid (rd_addr_grant_valid),
        .rd_data_master_sel  (rd_data_master_sel),
        .rd_data_id_err      (rd_data_id_err),
        .wq_count            (wq_count)
    );

    // Three-master instance for the out-of-range ID decode.
    axi_rr_master_arbiter #(.N_MASTER(N3), .M_ID(2), .ID_W(8), .WQ_DEPTH(4)) u_dut3 (
        .clk                 (clk),
        .rst                 (rst),
        .m_wr_addr_valid     (3'b000),
        .m_rd_addr_valid     (3'b000),
        .bus_wr_addr_ready   (1'b0),
        .bus_wr_data_valid   (1'b0),
        .bus_wr_data_ready   (1'b0),
        .bus_wr_data_last    (1'b0),
        .bus_rd_addr_ready   (1'b0),
        .bus_wr_back_id      (bus_wr_back_id),
        .bus_rd_back_id      (bus_rd_back_id),
        .wr_addr_master_sel  (d3_wr_addr_master_sel),
        .wr_addr_grant_valid (d3_wr_addr_grant_valid),
        .wr_data_master_sel  (d3_wr_data_master_sel),
        .wr_data_sel_valid   (d3_wr_data_sel_valid),
        .wr_resp_master_sel  (d3_wr_resp_master_sel),
        .wr_resp_id_err      (d3_wr_resp_id_err),
        .rd_addr_master_sel  (d3_rd_addr_master_sel),
        .rd_addr_grant_valid (d3_rd_addr_grant_valid),
        .rd_data_master_sel  (d3_rd_data_master_sel),
        .rd_data_id_err      (d3_rd_data_id_err),
        .wq_count            (d3_wq_count)
    );

    function automatic int actual_of(sig_e s);
        case (s)
            S_AW_SEL:   return int'(wr_addr_master_sel);
            S_AW_GV:    return int'(wr_addr_grant_valid);
            S_AR_SEL:   return int'(rd_addr_master_sel);
            S_AR_GV:    return int'(rd_addr_grant_valid);
            S_WD_SEL:   return int'(wr_data_master_sel);
            S_WD_VALID: return int'(wr_data_sel_valid);
            S_COUNT:    return int'(wq_count);
            S_WR_SEL:   return int'(wr_resp_master_sel);
            S_WR_ERR:   return int'(wr_resp_id_err);
            S_RD_SEL:   return int'(rd_data_master_sel);
            S_RD_ERR:   return int'(rd_data_id_err);
            S3_WR_SEL:  return int'(d3_wr_resp_master_sel);
            S3_WR_ERR:  return int'(d3_wr_resp_id_err);
            S3_RD_SEL:  return int'(d3_rd_data_master_sel);
            S3_RD_ERR:  return int'(d3_rd_data_id_err);
            default:    return -1;
        endcase
    endfunction

    task automatic check(input string name, input int at_cyc, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, at_cyc, actual, expected);
        end
    endtask

    task automatic exp_push(input sig_e s, input int v);
        sb_q.push_back('{cyc, s, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic v, input logic r, input logic l);
        bus_wr_data_valid = v;
        bus_wr_data_ready = r;
        bus_wr_data_last  = l;
    endtask

    // Monitor: compares every expectation tagged for the current cycle, away from the edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.cyc < cyc) begin
                check({e.sig.name(), "_missed"}, e.cyc, 0, 1);
            end else begin
                check(e.sig.name(), e.cyc, actual_of(e.sig), e.val);
            end
        end
    end

    initial begin
        if (cyc > 2000) $fatal(1, "FAIL watchdog");
    end
    always @(posedge clk) begin
        if (cyc > 2000) begin
            $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    initial begin
        // Reset: outputs gated even with requests pending and a valid response ID.
        m_wr_addr_valid = 4'hF;
        m_rd_addr_valid = 4'hF;
        bus_wr_back_id  = 8'h0C;
        bus_rd_back_id  = 8'h0C;
        step();
        exp_push(S_AW_SEL, 0); exp_push(S_AW_GV, 0); exp_push(S_AR_SEL, 0); exp_push(S_AR_GV, 0);
        exp_push(S_WD_SEL, 0); exp_push(S_WD_VALID, 0); exp_push(S_COUNT, 0);
        exp_push(S_WR_SEL, 0); exp_push(S_RD_SEL, 0);

        // All masters request, ready held: AW 0,1,2,3 then full; AR keeps rotating.
        step();
        rst = 1'b0;
        bus_wr_back_id = '0;
        bus_rd_back_id = '0;
        bus_wr_addr_ready = 1'b1;
        bus_rd_addr_ready = 1'b1;
        exp_push(S_AW_SEL, 0); exp_push(S_AW_GV, 1); exp_push(S_COUNT, 0);
        exp_push(S_AR_SEL, 0); exp_push(S_AR_GV, 1);
        for (int i = 1; i < 4; i++) begin
            step();
            exp_push(S_AW_SEL, i); exp_push(S_AW_GV, 1); exp_push(S_COUNT, i);
            exp_push(S_WD_SEL, 0); exp_push(S_WD_VALID, 1);
            exp_push(S_AR_SEL, i); exp_push(S_AR_GV, 1);
        end
        step();
        exp_push(S_AW_SEL, 0); exp_push(S_AW_GV, 0); exp_push(S_COUNT, 4);
        exp_push(S_AR_SEL, 0); exp_push(S_AR_GV, 1);

        // Drain in AW order; a non-last beat does not pop; pop on empty is ignored.
        step();
        m_wr_addr_valid = '0;
        m_rd_addr_valid = '0;
        set_w(1, 1, 0);
        exp_push(S_AW_SEL, 0); exp_push(S_AW_GV, 0); exp_push(S_AR_SEL, 0); exp_push(S_AR_GV, 0);
        exp_push(S_COUNT, 4); exp_push(S_WD_SEL, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            set_w(1, 1, 1);
            exp_push(S_WD_SEL, i); exp_push(S_COUNT, 4 - i);
        end
        step();
        exp_push(S_COUNT, 0); exp_push(S_WD_VALID, 0); exp_push(S_WD_SEL, 0);
        step();
        set_w(0, 0, 0);
        exp_push(S_COUNT, 0); exp_push(S_WD_VALID, 0);

        // Lock: master 2 stalled three cycles, master 1 joins and must wait.
        step();
        bus_wr_addr_ready = 1'b0;
        m_wr_addr_valid = 4'b0100;
        exp_push(S_AW_SEL, 2); exp_push(S_AW_GV, 1);
        for (int i = 0; i < 2; i++) begin
            step();
            m_wr_addr_valid = 4'b0110;
            exp_push(S_AW_SEL, 2); exp_push(S_AW_GV, 1);
        end
        step();
        bus_wr_addr_ready = 1'b1;
        exp_push(S_AW_SEL, 2); exp_push(S_AW_GV, 1); exp_push(S_COUNT, 0);
        step();
        m_wr_addr_valid = 4'b0010;
        exp_push(S_AW_SEL, 1); exp_push(S_AW_GV, 1); exp_push(S_COUNT, 1); exp_push(S_WD_SEL, 2);
        step();
        m_wr_addr_valid = '0;
        bus_wr_addr_ready = 1'b0;
        m_rd_addr_valid = 4'b0100;
        exp_push(S_AW_SEL, 1); exp_push(S_AW_GV, 0); exp_push(S_COUNT, 2); exp_push(S_WD_SEL, 2);
        exp_push(S_AR_SEL, 2); exp_push(S_AR_GV, 1);

        // Both channels locked, W burst in progress, two entries queued; then reset.
        step();
        m_wr_addr_valid = 4'b1000;
        set_w(1, 1, 0);
        exp_push(S_AW_SEL, 3); exp_push(S_AW_GV, 1); exp_push(S_AR_SEL, 2); exp_push(S_AR_GV, 1);
        exp_push(S_COUNT, 2); exp_push(S_WD_SEL, 2);
        step();
        rst = 1'b1;
        exp_push(S_AW_SEL, 0); exp_push(S_AW_GV, 0); exp_push(S_AR_SEL, 0); exp_push(S_AR_GV, 0);
        exp_push(S_WD_SEL, 0);
        step();
        rst = 1'b0;
        set_w(0, 0, 0);
        m_wr_addr_valid = 4'b1010;
        m_rd_addr_valid = 4'b1111;
        bus_wr_addr_ready = 1'b1;
        bus_rd_addr_ready = 1'b1;
        exp_push(S_COUNT, 0); exp_push(S_WD_VALID, 0); exp_push(S_WD_SEL, 0);
        exp_push(S_AW_SEL, 1); exp_push(S_AW_GV, 1); exp_push(S_AR_SEL, 0); exp_push(S_AR_GV, 1);

        // Masters 1 then 3 win AW; a 4-beat burst with one stalled beat drains master 1.
        step();
        m_wr_addr_valid = 4'b1000;
        exp_push(S_AW_SEL, 3); exp_push(S_AW_GV, 1); exp_push(S_COUNT, 1); exp_push(S_WD_SEL, 1);
        exp_push(S_AR_SEL, 1); exp_push(S_AR_GV, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            m_wr_addr_valid = '0;
            m_rd_addr_valid = '0;
            bus_wr_addr_ready = 1'b0;
            bus_rd_addr_ready = 1'b0;
            set_w(1, 1, 0);
            exp_push(S_COUNT, 2); exp_push(S_WD_SEL, 1);
        end
        step();
        set_w(1, 0, 1);
        exp_push(S_COUNT, 2); exp_push(S_WD_SEL, 1); exp_push(S_AW_SEL, 3); exp_push(S_AW_GV, 0);
        step();
        set_w(1, 1, 1);
        exp_push(S_COUNT, 2); exp_push(S_WD_SEL, 1);
        step();
        set_w(0, 0, 0);
        exp_push(S_COUNT, 1); exp_push(S_WD_SEL, 3); exp_push(S_WD_VALID, 1);

        // Push and pop in the same cycle: count holds, head moves to the new entry.
        step();
        m_wr_addr_valid = 4'b0100;
        bus_wr_addr_ready = 1'b1;
        set_w(1, 1, 1);
        exp_push(S_AW_SEL, 2); exp_push(S_AW_GV, 1); exp_push(S_COUNT, 1); exp_push(S_WD_SEL, 3);
        step();
        m_wr_addr_valid = '0;
        bus_wr_addr_ready = 1'b0;
        set_w(0, 0, 0);
        exp_push(S_COUNT, 1); exp_push(S_WD_SEL, 2); exp_push(S_WD_VALID, 1);

        // Response decode, including out-of-range master index on the 3-master instance.
        step();
        bus_rd_back_id = 8'h0C;
        bus_wr_back_id = 8'h07;
        exp_push(S_RD_SEL, 3); exp_push(S_RD_ERR, 0); exp_push(S_WR_SEL, 1); exp_push(S_WR_ERR, 0);
        exp_push(S3_RD_SEL, 0); exp_push(S3_RD_ERR, 1);
        step();
        bus_rd_back_id = 8'h08;
        bus_wr_back_id = 8'hF0;
        exp_push(S_RD_SEL, 2); exp_push(S3_RD_SEL, 2); exp_push(S3_RD_ERR, 0); exp_push(S_WR_SEL, 0);
        step();
        bus_wr_back_id = 8'h0C;
        exp_push(S_WR_SEL, 3); exp_push(S_WR_ERR, 0); exp_push(S3_WR_SEL, 0); exp_push(S3_WR_ERR, 1);

        // Let the monitor consume everything, bounded.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.sig.name(), "_unchecked"}, e.cyc, 0, 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
